fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Parametrised instruction-fetch unit with an in-order prefetch queue. It is the successor to the single-entry stage1 fetch. It issues sequential word fetches over a request/grant memory port and tolerates any response latency of 1 or more cycles. Fetched instructions are buffered for stage2 decode. On a taken branch from stage4 it flushes the queue and discards any responses still in flight.

Parameters:
ADDR_W, 30, word-address width (pc and memory address)
DATA_W, 32, instruction width
DEPTH, 4, queue entries; power of two, at least 2; bounds outstanding requests plus buffered entries
RESET_PC, 0, word address fetched first after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
take_branch_i  in  1  stage4 redirect strobe
branch_pc_i  in  ADDR_W  redirect target (word address)
stall_i  in  1  decode not accepting this cycle
valid_o  out  1  queue head holds a returned instruction
ir_o  out  DATA_W  head instruction
nextpc_o  out  ADDR_W  head word address + 1
re_o  out  1  memory read request
addr_o  out  ADDR_W  request word address (= pc)
gnt_i  in  1  request accepted this cycle
rvalid_i  in  1  read response valid (responses return in order)
rdata_i  in  DATA_W  read response data

Behaviour:
- Reset is synchronous and active-high on clk. It sets pc=RESET_PC, all pointers to 0 and drop=0. After reset: valid_o=0, re_o=0, ir_o=0, nextpc_o=0. Reset asserted mid-operation abandons everything, including in-flight responses; the memory side is reset by the same rst.
- Storage: DEPTH slots, each holding {addr, data, filled}. Three pointers: alloc, fill and read, each log2(DEPTH)+1 bits. occupancy = alloc-read.
- Issue: re_o = !rst && !take_branch_i && (occupancy+drop < DEPTH). addr_o = pc.
- On re_o && gnt_i:
  - slot[alloc] gets addr=pc, filled=0
  - alloc increments
  - pc <= pc+1, modulo 2^ADDR_W, so it wraps to 0
- re_o may stay high while gnt_i=0; addr_o stays stable until granted.
- Response, when rvalid_i and drop>0: the data is discarded and drop decrements.
- Response, when rvalid_i, drop=0 and fill!=alloc: slot[fill].data <= rdata_i, slot[fill].filled=1, fill increments.
- rvalid_i with nothing outstanding is a protocol error; it is ignored with no state change.
- Output: valid_o = slot[read].filled && occupancy!=0 && !take_branch_i. ir_o = slot[read].data. nextpc_o = slot[read].addr+1, also wrapping. All outputs are combinational from queue state, so the minimum latency from response to valid_o is 1 cycle.
- Dequeue on valid_o && !stall_i: read increments. Issue, fill and dequeue may all occur in the same cycle.
- Flush on take_branch_i (takes priority over every other action):
  - pc <= branch_pc_i
  - alloc, fill and read are set equal (queue emptied)
  - drop <= drop + (alloc-fill) - (1 if rvalid_i this cycle else 0)
  - no issue and no dequeue happen in the flush cycle
  - the first request to branch_pc_i goes out the next cycle
- Back-to-back branches are legal; each one recomputes drop.
- Full condition: occupancy+drop = DEPTH forces re_o=0 until a dequeue or a dropped response frees a credit.
- Empty condition: valid_o=0. stall_i is a don't-care when valid_o=0.

Test Plan:
- Reset, then gnt_i=1, 1-cycle rvalid, stall_i=0, memory returns data = 0xA000_0000|addr:
  - addr_o sequence is 0,1,2,…
  - ir_o sequence is 0xA0000000, 0xA0000001, …; nextpc_o sequence is 1,2,…
  - after fill-up, valid_o is high every cycle
- Backpressure: hold stall_i=1 with DEPTH=4:
  - exactly 4 grants occur, then re_o=0
  - releasing stall_i gives 4 consecutive valid_o with addrs 0–3 in order
- Redirect with 2 responses in flight, using 3-cycle latency:
  - assert take_branch_i with branch_pc_i=0x100
  - the 2 stale responses are dropped
  - the first valid_o shows ir for 0x100 with nextpc_o=0x101
  - no stale ir ever appears
- Wrap-around: RESET_PC=2^30-2 → fetched addrs are 0x3FFFFFFE, 0x3FFFFFFF, 0x0; nextpc_o of the second is 0.
- Grant stalls with random gnt_i/rvalid_i latency: addr_o is held while gnt_i=0; no instruction is lost or duplicated over 1000 fetches.
- Reset asserted mid-stream with 3 outstanding:
  - the next cycle has valid_o=0 and re_o=0
  - fetch restarts at RESET_PC
  - drop=0, since memory is reset too

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit with an in-order prefetch queue.
// Sequential word fetches go out over a request/grant port. Responses return
// in order with any latency of one cycle or more and fill the queue slots in
// the order the slots were allocated. A taken branch empties the queue and
// counts the responses still in flight so they can be discarded on arrival.
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              take_branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] ir_o,
  output logic [ADDR_W-1:0] nextpc_o,
  output logic              re_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              filled;
  } slot_t;

  slot_t             slots [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     alloc_ptr, fill_ptr, read_ptr;
  logic [PW-1:0]     drop;       // responses still owed to flushed requests
  logic [PW-1:0]     occ, inflight;
  logic [PW:0]       credits_used;
  logic              issue, fill, discard, rsp_taken, dequeue, head_ok;
  slot_t             head;

  assign occ          = alloc_ptr - read_ptr;
  assign inflight     = alloc_ptr - fill_ptr;
  // Every queued slot and every response still to be dropped holds a credit.
  assign credits_used = {1'b0, occ} + {1'b0, drop};

  assign re_o   = !rst && !take_branch_i && (credits_used < (PW+1)'(DEPTH));
  assign addr_o = pc;
  assign issue  = re_o && gnt_i;

  // Stale responses are always older than live ones, so they are consumed first.
  assign discard   = rvalid_i && (drop != '0);
  assign fill      = rvalid_i && (drop == '0) && (inflight != '0);
  assign rsp_taken = discard || fill;

  assign head    = slots[read_ptr[IW-1:0]];
  assign head_ok = head.filled && (occ != '0);
  assign valid_o = head_ok && !take_branch_i;
  // Head fields are zeroed while no returned instruction sits at the head, so
  // the outputs read zero out of reset and after a flush.
  assign ir_o     = head_ok ? head.data : '0;
  assign nextpc_o = head_ok ? head.addr + ADDR_W'(1) : '0;
  assign dequeue  = valid_o && !stall_i;

  // Pointer, pc and drop-counter update; a branch overrides issue, fill and dequeue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop      <= '0;
    end else if (take_branch_i) begin
      pc       <= branch_pc_i;
      fill_ptr <= alloc_ptr;
      read_ptr <= alloc_ptr;
      // A response accepted this very cycle is no longer owed.
      drop     <= drop + inflight - PW'(rsp_taken);
    end else begin
      if (issue) begin
        pc        <= pc + ADDR_W'(1);
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (discard) drop     <= drop - PW'(1);
      if (fill)    fill_ptr <= fill_ptr + PW'(1);
      if (dequeue) read_ptr <= read_ptr + PW'(1);
    end
  end

  // Slot storage: allocation records the address, a response supplies the data.
  // The two never target the same slot since allocation stops when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
    end else if (!take_branch_i) begin
      if (issue) begin
        slots[alloc_ptr[IW-1:0]].addr   <= pc;
        slots[alloc_ptr[IW-1:0]].filled <= 1'b0;
      end
      if (fill) begin
        slots[fill_ptr[IW-1:0]].data   <= rdata_i;
        slots[fill_ptr[IW-1:0]].filled <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with configurable
// latency and grant behaviour, plus a queue of expected fetch addresses.
module tb_fetch_prefetch_queue;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [AW-1:0] ZERO_PC = '0;
  localparam logic [AW-1:0] WRAP_PC = 30'h3FFF_FFFE;
  localparam logic [AW-1:0] BR_PC   = 30'h100;

  logic clk = 1'b0;
  logic rst, take_branch_i, stall_i, gnt_i, rvalid_i, w_rvalid;
  logic [AW-1:0] branch_pc_i, addr_o, nextpc_o, w_addr, w_nextpc;
  logic [DW-1:0] rdata_i, ir_o, w_rdata, w_ir;
  logic valid_o, re_o, w_valid, w_re;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(ZERO_PC)) dut (
    .clk(clk), .rst(rst), .take_branch_i(take_branch_i), .branch_pc_i(branch_pc_i),
    .stall_i(stall_i), .valid_o(valid_o), .ir_o(ir_o), .nextpc_o(nextpc_o),
    .re_o(re_o), .addr_o(addr_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i));

  // Second instance starting near the top of the address space.
  fetch_prefetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .take_branch_i(take_branch_i), .branch_pc_i(branch_pc_i),
    .stall_i(stall_i), .valid_o(w_valid), .ir_o(w_ir), .nextpc_o(w_nextpc),
    .re_o(w_re), .addr_o(w_addr), .gnt_i(gnt_i), .rvalid_i(w_rvalid), .rdata_i(w_rdata));

  typedef struct { logic [AW-1:0] addr; int due; } req_t;
  typedef struct { logic [DW-1:0] ir; logic [AW-1:0] npc; } out_t;

  req_t          pend[$];
  req_t          w_pend[$];
  logic [AW-1:0] exp_q[$];
  out_t          w_out[$];

  int tests = 0, fails = 0, cyc = 0, grants = 0, deq_cnt = 0;
  int lat_min = 1, lat_max = 1;
  bit gnt_rand = 1'b0, gnt_en = 1'b1;
  bit last_valid, last_re;
  logic [AW-1:0] iss_pc = '0, first_deq = '0, last_addr;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA000_0000 | {2'b00, a};
  endfunction

  // One clock: drive inputs at negedge, check settled outputs, advance models.
  task automatic step(input logic br, input logic [AW-1:0] bpc, input logic stl);
    logic [AW-1:0] e, e1;
    req_t r;
    out_t o;
    @(negedge clk);
    take_branch_i = br; branch_pc_i = bpc; stall_i = stl;
    gnt_i    = gnt_rand ? ($urandom_range(0, 2) != 0) : gnt_en;
    rvalid_i = !rst && (pend.size() != 0) && (pend[0].due <= cyc);
    rdata_i  = rvalid_i ? mem_word(pend[0].addr) : '0;
    w_rvalid = !rst && (w_pend.size() != 0) && (w_pend[0].due <= cyc);
    w_rdata  = w_rvalid ? mem_word(w_pend[0].addr) : '0;
    #1;
    last_valid = valid_o; last_re = re_o; last_addr = addr_o;
    if (!rst) begin
      if (re_o) begin
        tests++;
        if (addr_o !== iss_pc) begin
          fails++; $display("FAIL addr_o: got %h want %h (cycle %0d)", addr_o, iss_pc, cyc);
        end
      end
      if (valid_o && !stl) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL unexpected_valid: got ir %h want no instruction (cycle %0d)", ir_o, cyc);
        end else begin
          e  = exp_q.pop_front();
          e1 = e + 30'd1;
          if (ir_o !== mem_word(e) || nextpc_o !== e1) begin
            fails++;
            $display("FAIL dequeue: got ir %h nextpc %h want ir %h nextpc %h (cycle %0d)",
                     ir_o, nextpc_o, mem_word(e), e1, cyc);
          end
          if (deq_cnt == 0) first_deq = e;
          deq_cnt++;
        end
      end
    end
    if (rst) begin
      iss_pc = ZERO_PC; exp_q.delete(); pend.delete(); w_pend.delete(); w_out.delete();
    end else begin
      if (br) begin
        iss_pc = bpc; exp_q.delete();
      end else if (re_o && gnt_i) begin
        exp_q.push_back(iss_pc);
        r.addr = iss_pc; r.due = cyc + int'($urandom_range(lat_min, lat_max));
        pend.push_back(r);
        iss_pc = iss_pc + 30'd1;
        grants++;
      end
      if (rvalid_i) void'(pend.pop_front());
      if (w_re && gnt_i) begin
        r.addr = w_addr; r.due = cyc + lat_min;
        w_pend.push_back(r);
      end
      if (w_rvalid) void'(w_pend.pop_front());
      if (w_valid && !stl) begin
        o.ir = w_ir; o.npc = w_nextpc;
        w_out.push_back(o);
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, ZERO_PC, 1'b0);
    step(1'b0, ZERO_PC, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, ZERO_PC, 1'b0);
    step(1'b0, ZERO_PC, 1'b0);
    #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    tests++; if (re_o !== 1'b0) begin fails++; $display("FAIL reset_re: got %b want 0", re_o); end
    tests++; if (ir_o !== '0) begin fails++; $display("FAIL reset_ir: got %h want 0", ir_o); end
    tests++; if (nextpc_o !== '0) begin fails++; $display("FAIL reset_nextpc: got %h want 0", nextpc_o); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int vcount = 0;
    do_reset();
    lat_min = 1; lat_max = 1; gnt_en = 1'b1; deq_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, ZERO_PC, 1'b0);
      if (i >= 10 && last_valid) vcount++;
    end
    tests++; if (deq_cnt !== 18) begin fails++; $display("FAIL stream_count: got %0d want 18", deq_cnt); end
    tests++; if (vcount !== 10) begin fails++; $display("FAIL stream_steady: got %0d want 10", vcount); end
    tests++; if (first_deq !== ZERO_PC) begin fails++; $display("FAIL stream_first: got %h want 0", first_deq); end
  endtask

  task automatic test_backpressure();
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) step(1'b0, ZERO_PC, 1'b1);
    tests++; if (grants !== 4) begin fails++; $display("FAIL bp_grants: got %0d want 4", grants); end
    tests++; if (last_re !== 1'b0) begin fails++; $display("FAIL bp_re_full: got %b want 0", last_re); end
    deq_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b0, ZERO_PC, 1'b0);
    tests++; if (deq_cnt !== 4) begin fails++; $display("FAIL bp_release: got %0d want 4", deq_cnt); end
    tests++; if (first_deq !== ZERO_PC) begin fails++; $display("FAIL bp_first: got %h want 0", first_deq); end
  endtask

  task automatic test_redirect();
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b0, ZERO_PC, 1'b0);
    step(1'b0, ZERO_PC, 1'b0);
    tests++; if (pend.size() !== 2) begin fails++; $display("FAIL redir_inflight: got %0d want 2", pend.size()); end
    deq_cnt = 0;
    step(1'b1, BR_PC, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, ZERO_PC, 1'b0);
    tests++; if (deq_cnt < 1) begin fails++; $display("FAIL redir_progress: got %0d want >0", deq_cnt); end
    tests++; if (first_deq !== BR_PC) begin fails++; $display("FAIL redir_first: got %h want %h", first_deq, BR_PC); end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ir_exp [3];
    logic [AW-1:0] np_exp [3];
    ir_exp[0] = mem_word(30'h3FFF_FFFE); np_exp[0] = 30'h3FFF_FFFF;
    ir_exp[1] = mem_word(30'h3FFF_FFFF); np_exp[1] = 30'h0;
    ir_exp[2] = mem_word(30'h0);         np_exp[2] = 30'h1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, ZERO_PC, 1'b0);
    tests++;
    if (w_out.size() < 3) begin
      fails++; $display("FAIL wrap_count: got %0d want >=3", w_out.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (w_out[k].ir !== ir_exp[k] || w_out[k].npc !== np_exp[k]) begin
          fails++;
          $display("FAIL wrap_%0d: got ir %h nextpc %h want ir %h nextpc %h",
                   k, w_out[k].ir, w_out[k].npc, ir_exp[k], np_exp[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] bpc;
    do_reset();
    gnt_rand = 1'b1; lat_min = 1; lat_max = 4; deq_cnt = 0;
    for (int c = 0; c < 20000 && deq_cnt < 1000; c++) begin
      bpc = AW'($urandom());
      step($urandom_range(0, 49) == 0, bpc, $urandom_range(0, 3) == 0);
    end
    tests++; if (deq_cnt < 1000) begin fails++; $display("FAIL rand_timeout: got %0d want 1000", deq_cnt); end
    gnt_rand = 1'b0; gnt_en = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, ZERO_PC, 1'b0);
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_lost: got %0d undelivered want 0", exp_q.size()); end
    gnt_en = 1'b1; lat_min = 1; lat_max = 1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) step(1'b0, ZERO_PC, 1'b0);
    rst = 1'b1;
    step(1'b0, ZERO_PC, 1'b0);
    tests++; if (last_valid !== 1'b0 || last_re !== 1'b0) begin
      fails++; $display("FAIL midrst_quiet: got valid %b re %b want 0 0", last_valid, last_re);
    end
    #1; rst = 1'b0;
    lat_min = 1; lat_max = 1; deq_cnt = 0;
    step(1'b0, ZERO_PC, 1'b0);
    tests++; if (last_valid !== 1'b0 || last_re !== 1'b1 || last_addr !== ZERO_PC) begin
      fails++; $display("FAIL midrst_restart: got valid %b re %b addr %h want 0 1 0", last_valid, last_re, last_addr);
    end
    for (int i = 0; i < 10; i++) step(1'b0, ZERO_PC, 1'b0);
    tests++; if (deq_cnt !== 9) begin fails++; $display("FAIL midrst_count: got %0d want 9", deq_cnt); end
    tests++; if (first_deq !== ZERO_PC) begin fails++; $display("FAIL midrst_first: got %h want 0", first_deq); end
  endtask

  initial begin
    rst = 1'b1; take_branch_i = 1'b0; branch_pc_i = '0; stall_i = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; w_rvalid = 1'b0; w_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
